// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI requester arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    LAUNCH = 3'd2,
    XFER   = 3'd3,
    ACK    = 3'd4
  } arb_state_t;

  localparam int SPI_DW      = 12;
  localparam int ARB_TIMEOUT = 4096;
  localparam int ID_W        = 3;

endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  logic [7:0] req_ext;
  logic [3:0] idx;

  assign req_ext = 8'(req);

  // Walk offsets from farthest to nearest so the nearest set request wins last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      if (req_ext[idx[2:0]]) begin
        winner = idx[2:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters.
// Optional launch-to-done watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no frame owned; waits for any request
// GRANT  | pick winner, latch id and frame
// LAUNCH | spi_start held until master pulls cs low
// XFER   | frame shifting; waits for rising done
// ACK    | ack/err pulse to winner, advance rr pointer
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = SPI_DW,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    err,
  output logic                busy,
  output logic [ID_W-1:0]     grant_id,
  output logic                spi_start,
  output logic [DW-1:0]       spi_din,
  input  logic                spi_cs,
  input  logic                spi_done
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("spi_req_arbiter: N_REQ must be 2..8 and TIMEOUT >= 2");
  end

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_next;
  logic [ID_W-1:0] pick_id;
  logic            pick_valid;
  logic [DW-1:0]   pick_data;
  logic [N_REQ-1:0] grant_mask;
  logic            cs_q;
  logic            done_q;
  logic            done_qq;
  logic            done_rise;
  logic            tmo_hit;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_id == ID_W'(i)) pick_data = req_data[i*DW +: DW];
    end
  end

  assign grant_mask = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign rr_next    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign done_rise  = done_q & ~done_qq;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Down-counter loaded at grant; terminal count 1 lands err exactly TIMEOUT cycles after GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == GRANT) begin
      tmo_cnt <= TW'(TIMEOUT - 1);
    end else if ((state == LAUNCH || state == XFER) && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign tmo_hit = (state == LAUNCH || state == XFER) && (tmo_cnt == TW'(1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      ack       <= '0;
      err       <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      spi_start <= 1'b0;
      spi_din   <= '0;
      cs_q      <= 1'b1;
      done_q    <= 1'b0;
      done_qq   <= 1'b0;
    end else begin
      cs_q    <= spi_cs;
      done_q  <= spi_done;
      done_qq <= done_q;
      ack     <= '0;
      err     <= '0;
      case (state)
        IDLE: begin
          if (|req) state <= GRANT;
        end
        GRANT: begin
          if (pick_valid) begin
            grant_id  <= pick_id;
            spi_din   <= pick_data;
            busy      <= 1'b1;
            spi_start <= 1'b1;
            state     <= LAUNCH;
          end else begin
            state <= IDLE;
          end
        end
        LAUNCH: begin
          if (tmo_hit) begin
            spi_start <= 1'b0;
            err       <= grant_mask;
            state     <= ACK;
          end else if (!cs_q) begin
            spi_start <= 1'b0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (tmo_hit) begin
            err   <= grant_mask;
            state <= ACK;
          end else if (done_rise) begin
            ack   <= grant_mask;
            state <= ACK;
          end
        end
        ACK: begin
          busy   <= 1'b0;
          rr_ptr <= rr_next;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter with a behavioural SPI master (sclk = clk/22).
module tb_spi_req_arbiter;

  localparam int N    = 4;
  localparam int DW   = 12;
  localparam int SCLK = 22;

  typedef struct {
    int id;
    int kind;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic            busy;
  logic [2:0]      grant_id;
  logic            spi_start;
  logic [DW-1:0]   spi_din;
  logic            spi_cs;
  logic            spi_done;

  int n_tests = 0;
  int n_fail  = 0;
  int issued[N];
  int acked[N];

  exp_t          exp_q[$];
  logic [DW-1:0] exp_data_q[$];

  logic          m_busy;
  logic          force_done;
  int            drop_req;
  int            drop_done;
  logic [DW-1:0] rx;
  logic [N-1:0]  prev_ack;
  logic [N-1:0]  prev_err;
  logic          busy_chk_pend;

  spi_req_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .grant_id  (grant_id),
    .spi_start (spi_start),
    .spi_din   (spi_din),
    .spi_cs    (spi_cs),
    .spi_done  (spi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) req[i] = (issued[i] != acked[i]);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SPI master: start sampled while idle, cs low for 12 bits, then done.
  initial begin
    m_busy = 1'b0; spi_cs = 1'b1; spi_done = 1'b0; rx = '0; drop_done = 0;
  end
  always begin
    @(negedge clk);
    if (spi_start && !m_busy) begin
      m_busy = 1'b1;
      rx = '0;
      repeat (SCLK) @(negedge clk);
      spi_cs = 1'b0;
      for (int b = 0; b < DW; b++) begin
        repeat (SCLK) @(negedge clk);
        rx[b] = spi_din[b];
      end
      spi_cs = 1'b1;
      if (!force_done) spi_done = 1'b1;
      repeat (SCLK) @(negedge clk);
      spi_done = 1'b0;
      repeat (SCLK) @(negedge clk);
      if (drop_done < drop_req) drop_done++;
      else if (exp_data_q.size() == 0) check_eq("rx_pending", exp_data_q.size(), 1);
      else check_eq("rx_data", rx, exp_data_q.pop_front());
      m_busy = 1'b0;
    end
  end

  // Pulse monitor: pops the id/kind scoreboard on every ack or err pulse.
  initial begin
    prev_ack = '0; prev_err = '0; busy_chk_pend = 1'b0;
  end
  always @(negedge clk) begin
    exp_t e;
    if (busy_chk_pend) begin
      check_eq("busy_after", busy, 0);
      busy_chk_pend = 1'b0;
    end
    if (ack != '0 || err != '0) begin
      check_eq("pulse_onehot", $countones({ack, err}), 1);
      check_eq("pulse_width", {prev_ack, prev_err}, 0);
      check_eq("busy_at_pulse", busy, 1);
      for (int i = 0; i < N; i++) begin
        if (ack[i] || err[i]) begin
          acked[i]++;
          if (exp_q.size() == 0) check_eq("sb_pending", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check_eq("pulse_id", i, e.id);
            check_eq("pulse_kind", err[i], e.kind);
          end
        end
      end
      busy_chk_pend = 1'b1;
    end
    prev_ack = ack;
    prev_err = err;
  end

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic issue(input int i, input logic [DW-1:0] v, input bit expect_frame);
    exp_t e;
    issued[i]++;
    if (expect_frame) begin
      e.id = i; e.kind = 0;
      exp_q.push_back(e);
      exp_data_q.push_back(v);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_start", spi_start, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_din", spi_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp_data_q.size() != 0 || m_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_in_budget", n < budget, 1);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_in_budget", n < 50, 1);
  endtask

  task automatic wait_master_idle();
    int n = 0;
    while (m_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("master_idle", n < 2000, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin issued[i] = 0; acked[i] = 0; end
    rst_n = 1'b0; req_data = '0; force_done = 1'b0; drop_req = 0;
    set_data(0, 12'h111); set_data(1, 12'h222); set_data(2, 12'h333); set_data(3, 12'h444);
    apply_reset();
    repeat (2) @(negedge clk);

    // 1: single requester, latency and one frame
    set_data(0, 12'hA5C);
    issue(0, 12'hA5C, 1);
    n = 0;
    while (!spi_start && n < 10) begin @(negedge clk); n++; end
    check_eq("start_latency", n, 2);
    wait_done(1000);
    check_eq("t1_busy_low", busy, 0);

    // 2: all four held, rr from 0 -> 0,1,2,3 then 0 again
    apply_reset();
    @(negedge clk);
    set_data(0, 12'h0A1); set_data(1, 12'h1B2); set_data(2, 12'h2C3); set_data(3, 12'h3D4);
    issue(0, 12'h0A1, 1); issue(1, 12'h1B2, 1); issue(2, 12'h2C3, 1); issue(3, 12'h3D4, 1);
    issue(0, 12'h0A1, 1);
    wait_done(4000);

    // 3: rr_ptr now 1; one req2 frame moves it to 3, next req2 grant wraps
    set_data(2, 12'h5A3);
    issue(2, 12'h5A3, 1);
    wait_done(1000);
    set_data(2, 12'h3C7);
    issue(2, 12'h3C7, 1);
    wait_busy();
    check_eq("wrap_grant_id", grant_id, 2);
    check_eq("wrap_din", spi_din, 12'h3C7);
    wait_done(1000);

    // 4: data change after grant is ignored
    set_data(1, 12'h123);
    issue(1, 12'h123, 1);
    wait_busy();
    set_data(1, 12'hFFF);
    repeat (5) @(negedge clk);
    check_eq("latched_din", spi_din, 12'h123);
    wait_done(1000);

    // 5: reset mid-XFER, then a normal frame
    set_data(1, 12'h2B6);
    issue(1, 12'h2B6, 0);
    n = 0;
    while (!spi_start && n < 20) begin @(negedge clk); n++; end
    while (spi_start && n < 100) begin @(negedge clk); n++; end
    check_eq("t5_reach_xfer", n < 100, 1);
    repeat (40) @(negedge clk);
    drop_req++;
    issued[1] = acked[1];
    apply_reset();
    wait_master_idle();
    @(negedge clk);
    set_data(1, 12'h6E9);
    issue(1, 12'h6E9, 1);
    wait_done(1000);

    // 6: done never arrives
    force_done = 1'b1;
    apply_reset();
    @(negedge clk);
`ifdef SPI_ARB_TIMEOUT_EN
    begin
      exp_t e;
      e.id = 0; e.kind = 1;
      exp_q.push_back(e);
      drop_req++;
      issued[0]++;
      wait_busy();
      n = 0;
      while (err == '0 && n < 200) begin @(negedge clk); n++; end
      check_eq("tmo_cycles", n, 63);
      check_eq("tmo_err_id", err, 4'b0001);
      wait_done(1000);
    end
`else
    begin
      logic saw_err;
      saw_err = 1'b0;
      drop_req++;
      issued[0]++;
      wait_busy();
      repeat (200) begin
        @(negedge clk);
        if (err != '0) saw_err = 1'b1;
      end
      check_eq("no_tmo_err", saw_err, 0);
      check_eq("no_tmo_busy", busy, 1);
      wait_master_idle();
      issued[0] = acked[0];
      apply_reset();
    end
`endif
    force_done = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
